store_size_unit: RTL

//  Store-path counterpart of the load/write-back path: moves register data (B) out to memory for sw/sh/sb.

---
 rtl/store_size_unit.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/store_size_unit.sv
// store_size_unit
//   Store path from the B register to memory for sw/sh/sb. Word stores are
//   written directly. Halfword and byte stores read the aligned memory word,
//   merge the new lane(s) in, and write the whole word back.
//   The unit is started by the control FSM with a one-cycle start pulse and
//   reports completion with a one-cycle done pulse.
//
// Parameters
//   MEM_RD_LAT  cycles from mem_addr valid (mem_wr=0) to mem_rdata valid, 1..7
//
// Ports
//   clk         system clock, rising edge
//   reset_n     asynchronous active-low reset
//   start       one-cycle request, ignored while busy
//   ss_ctrl     00 word, 01 halfword, 10 byte, 11 illegal (misaligned)
//   addr        byte address from the ALU
//   reg_data    data to store; byte/half taken from the low bits
//   mem_rdata   memory read data
//   mem_addr    word-aligned memory address
//   mem_wdata   merged write word, zero outside the write cycle
//   mem_wr      write strobe, one cycle per successful store
//   busy        high from the cycle after an accepted start until DONE exits
//   done        one-cycle completion pulse
//   misaligned  valid with done; 1 means no write was performed
module store_size_unit #(
   parameter int unsigned MEM_RD_LAT = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [1:0]  ss_ctrl,
   input  logic [31:0] addr,
   input  logic [31:0] reg_data,
   input  logic [31:0] mem_rdata,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_wr,
   output logic        busy,
   output logic        done,
   output logic        misaligned
);

   localparam logic [1:0] SS_WORD = 2'b00;
   localparam logic [1:0] SS_HALF = 2'b01;
   localparam logic [1:0] SS_BYTE = 2'b10;

   // Counter reload: READ lasts MEM_RD_LAT cycles, counting down to zero.
   localparam logic [2:0] RD_LAST = 3'(MEM_RD_LAT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_READ,
      S_LATCH,
      S_WRITE,
      S_DONE
   } state_t;

   state_t      state_q;
   logic [31:0] addr_q;
   logic [1:0]  ss_q;
   logic [31:0] data_q;
   logic [2:0]  cnt_q;
   logic [31:0] mem_addr_q;
   logic [31:0] mem_wdata_q;
   logic        mem_wr_q;
   logic        busy_q;
   logic        done_q;
   logic        misaligned_q;

   logic        mis_d;
   logic [31:0] merged_d;

   always_comb begin
      mis_d = 1'b0;
      case (ss_q)
         SS_WORD: mis_d = (addr_q[1:0] != 2'b00);
         SS_HALF: mis_d = addr_q[0];
         SS_BYTE: mis_d = 1'b0;
         default: mis_d = 1'b1;
      endcase
   end

   // Little-endian lane merge: lane k occupies bits [8k+7:8k].
   always_comb begin
      merged_d = mem_rdata;
      if (ss_q == SS_HALF) begin
         merged_d[{addr_q[1], 4'b0000} +: 16] = data_q[15:0];
      end else begin
         merged_d[{addr_q[1:0], 3'b000} +: 8] = data_q[7:0];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         addr_q       <= '0;
         ss_q         <= '0;
         data_q       <= '0;
         cnt_q        <= '0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_wr_q     <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         misaligned_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  addr_q  <= addr;
                  ss_q    <= ss_ctrl;
                  data_q  <= reg_data;
                  busy_q  <= 1'b1;
                  state_q <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (mis_d) begin
                  misaligned_q <= 1'b1;
                  done_q       <= 1'b1;
                  state_q      <= S_DONE;
               end else begin
                  mem_addr_q <= {addr_q[31:2], 2'b00};
                  if (ss_q == SS_WORD) begin
                     mem_wdata_q <= data_q;
                     mem_wr_q    <= 1'b1;
                     state_q     <= S_WRITE;
                  end else begin
                     cnt_q   <= RD_LAST;
                     state_q <= S_READ;
                  end
               end
            end
            S_READ: begin
               if (cnt_q == 3'd0) begin
                  state_q <= S_LATCH;
               end else begin
                  cnt_q <= cnt_q - 3'd1;
               end
            end
            S_LATCH: begin
               // mem_rdata is valid in this cycle; the merged word goes straight
               // to the write-data register so WRITE presents it unchanged.
               mem_wdata_q <= merged_d;
               mem_wr_q    <= 1'b1;
               state_q     <= S_WRITE;
            end
            S_WRITE: begin
               mem_wr_q    <= 1'b0;
               mem_wdata_q <= '0;
               done_q      <= 1'b1;
               state_q     <= S_DONE;
            end
            S_DONE: begin
               done_q       <= 1'b0;
               busy_q       <= 1'b0;
               misaligned_q <= 1'b0;
               state_q      <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign mem_wr     = mem_wr_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign misaligned = misaligned_q;

endmodule
